mem_wb_stage: RTL and testbench

Memory-to-writeback pipeline stage of the pipelined RISC-V core. It latches the MEM-stage result bundle once per cycle and performs load byte-lane extraction and sign/zero extension. It selects the final write-back value and drives the register file write port (`rd`, `write_data`, `reg_write`) directly. Its registered outputs also serve as the WB-stage forwarding source for the hazard/forwarding logic.

---
 rtl/riscv_pkg.sv | 27 ++
 rtl/load_extend.sv | 48 ++++
 rtl/mem_wb_stage.sv | 92 +++++++++
 tb/tb_mem_wb_stage.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RISC-V core constants: datapath width, write-back result selects,
// load funct3 codes and the MEM/WB register bundle.
package riscv_pkg;

   localparam int XLEN = 64;

   localparam logic [1:0] RES_ALU  = 2'b00;
   localparam logic [1:0] RES_LOAD = 2'b01;
   localparam logic [1:0] RES_PC4  = 2'b10;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LD  = 3'b011;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_LWU = 3'b110;

   typedef struct packed {
      logic            valid;
      logic [4:0]      rd;
      logic [XLEN-1:0] data;
      logic            reg_write;
      logic            load_fault;
   } wb_bundle_t;

endpackage

// File: rtl/load_extend.sv
// Load lane extraction: shifts the aligned doubleword down by the byte offset,
// then sign/zero-extends to XLEN and flags misaligned or illegal load codes.
module load_extend
   import riscv_pkg::*;
(
   input  logic [XLEN-1:0] read_data,
   input  logic [2:0]      funct3,
   input  logic [2:0]      off,
   output logic [XLEN-1:0] load_value,
   output logic            fault
);

   logic [XLEN-1:0] shifted;

   // Little-endian: byte at address offset 'off' lands in bits [7:0].
   assign shifted = read_data >> {off, 3'b000};

   always_comb begin
      load_value = '0;
      fault      = 1'b0;
      case (funct3)
         F3_LB:  load_value = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         F3_LBU: load_value = {{(XLEN-8){1'b0}}, shifted[7:0]};
         F3_LH: begin
            load_value = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            fault      = off[0];
         end
         F3_LHU: begin
            load_value = {{(XLEN-16){1'b0}}, shifted[15:0]};
            fault      = off[0];
         end
         F3_LW: begin
            load_value = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            fault      = |off[1:0];
         end
         F3_LWU: begin
            load_value = {{(XLEN-32){1'b0}}, shifted[31:0]};
            fault      = |off[1:0];
         end
         F3_LD: begin
            load_value = shifted;
            fault      = |off;
         end
         default: fault = 1'b1;
      endcase
   end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register with load extraction and write-back select; drives
// the register file write port. Optional retire counter: MEM_WB_RETIRE_CNT_EN.
module mem_wb_stage #(
   parameter int XLEN = 64
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   stall,
   input  logic                   flush,
   input  logic                   mem_valid,
   input  logic [4:0]             mem_rd,
   input  logic                   mem_reg_write,
   input  logic [1:0]             mem_result_sel,
   input  logic [XLEN-1:0]        mem_alu_result,
   input  logic [XLEN-1:0]        mem_pc_plus4,
   input  logic [XLEN-1:0]        mem_read_data,
   input  logic [2:0]             mem_funct3,
   output logic                   wb_valid,
   output logic [4:0]             wb_rd,
   output logic signed [XLEN-1:0] wb_write_data,
   output logic                   wb_reg_write,
   output logic                   wb_load_fault
`ifdef MEM_WB_RETIRE_CNT_EN
   ,
   output logic [63:0]            retire_count
`endif
);

   // Only XLEN = 64 is supported; the load extender is sized by the package.
   logic [XLEN-1:0]        load_value;
   logic                   load_fault_raw;
   logic                   is_load;
   riscv_pkg::wb_bundle_t  wb_next;
   riscv_pkg::wb_bundle_t  wb_reg;

   load_extend u_load_extend (
      .read_data  (mem_read_data),
      .funct3     (mem_funct3),
      .off        (mem_alu_result[2:0]),
      .load_value (load_value),
      .fault      (load_fault_raw)
   );

   always_comb begin
      is_load            = (mem_result_sel == riscv_pkg::RES_LOAD);
      wb_next.valid      = mem_valid;
      wb_next.rd         = mem_rd;
      wb_next.load_fault = mem_valid & is_load & load_fault_raw;
      case (mem_result_sel)
         riscv_pkg::RES_LOAD: wb_next.data = load_value;
         riscv_pkg::RES_PC4:  wb_next.data = mem_pc_plus4;
         default:             wb_next.data = mem_alu_result;
      endcase
      // Write enable is resolved here so the register file sees a clean flop.
      wb_next.reg_write = mem_valid & mem_reg_write & (mem_rd != 5'd0)
                          & ~wb_next.load_fault;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wb_reg <= '0;
      end else if (flush) begin
         // Bubble: data and rd are left as they were.
         wb_reg.valid      <= 1'b0;
         wb_reg.reg_write  <= 1'b0;
         wb_reg.load_fault <= 1'b0;
      end else if (!stall) begin
         wb_reg <= wb_next;
      end
   end

   assign wb_valid      = wb_reg.valid;
   assign wb_rd         = wb_reg.rd;
   assign wb_write_data = wb_reg.data;
   assign wb_reg_write  = wb_reg.reg_write;
   assign wb_load_fault = wb_reg.load_fault;

`ifdef MEM_WB_RETIRE_CNT_EN
   logic [63:0] retire_count_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         retire_count_reg <= '0;
      end else if (mem_valid && !stall && !flush) begin
         retire_count_reg <= retire_count_reg + 64'd1;
      end
   end

   assign retire_count = retire_count_reg;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: per-cycle expected WB state is pushed when
// MEM inputs are driven and popped/compared after the capturing edge.
module tb_mem_wb_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall;
   logic        flush;
   logic        mem_valid;
   logic [4:0]  mem_rd;
   logic        mem_reg_write;
   logic [1:0]  mem_result_sel;
   logic [63:0] mem_alu_result;
   logic [63:0] mem_pc_plus4;
   logic [63:0] mem_read_data;
   logic [2:0]  mem_funct3;
   logic        wb_valid;
   logic [4:0]  wb_rd;
   logic signed [63:0] wb_write_data;
   logic        wb_reg_write;
   logic        wb_load_fault;
`ifdef MEM_WB_RETIRE_CNT_EN
   logic [63:0] retire_count;
`endif

   mem_wb_stage #(.XLEN(64)) dut (
      .clk            (clk),
      .reset          (reset),
      .stall          (stall),
      .flush          (flush),
      .mem_valid      (mem_valid),
      .mem_rd         (mem_rd),
      .mem_reg_write  (mem_reg_write),
      .mem_result_sel (mem_result_sel),
      .mem_alu_result (mem_alu_result),
      .mem_pc_plus4   (mem_pc_plus4),
      .mem_read_data  (mem_read_data),
      .mem_funct3     (mem_funct3),
      .wb_valid       (wb_valid),
      .wb_rd          (wb_rd),
      .wb_write_data  (wb_write_data),
      .wb_reg_write   (wb_reg_write),
      .wb_load_fault  (wb_load_fault)
`ifdef MEM_WB_RETIRE_CNT_EN
      ,
      .retire_count   (retire_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        valid;
      logic [4:0]  rd;
      logic [63:0] data;
      logic        data_known;
      logic        rw;
      logic        fault;
      logic [63:0] cnt;
   } exp_t;

   exp_t        sb_q[$];
   int          checks = 0;
   int          errors = 0;

   logic        m_valid, m_rw, m_fault, m_known;
   logic [4:0]  m_rd;
   logic [63:0] m_data, m_cnt;

   localparam logic [63:0] RDATA = 64'h8877665544332211;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Byte-at-a-time reference for the load path.
   function automatic void model_load(input logic [63:0] rdata, input logic [2:0] f3,
                                      input logic [2:0] off, output logic [63:0] val,
                                      output logic flt);
      int  nbytes;
      bit  sgn;
      int  o;
      o = int'(off);
      case (f3)
         3'd0: begin nbytes = 1; sgn = 1; end
         3'd1: begin nbytes = 2; sgn = 1; end
         3'd2: begin nbytes = 4; sgn = 1; end
         3'd3: begin nbytes = 8; sgn = 1; end
         3'd4: begin nbytes = 1; sgn = 0; end
         3'd5: begin nbytes = 2; sgn = 0; end
         3'd6: begin nbytes = 4; sgn = 0; end
         default: begin nbytes = 0; sgn = 0; end
      endcase
      flt = (nbytes == 0) || ((o % nbytes) != 0);
      val = 64'd0;
      for (int i = 0; i < nbytes; i++)
         if (o + i < 8) val[8*i +: 8] = rdata[8*(o+i) +: 8];
      if (sgn && nbytes > 0 && nbytes < 8 && val[8*nbytes-1])
         for (int j = nbytes; j < 8; j++) val[8*j +: 8] = 8'hFF;
   endfunction

   task automatic model_clear();
      m_valid = 0; m_rw = 0; m_fault = 0; m_rd = 0; m_data = 0; m_cnt = 0; m_known = 1;
   endtask

   task automatic step(input string name, input logic v, input logic rw, input logic [4:0] rd,
                       input logic [1:0] sel, input logic [63:0] alu, input logic [63:0] pc4,
                       input logic [63:0] rdat, input logic [2:0] f3,
                       input logic st, input logic fl);
      logic [63:0] lv;
      logic        lf, is_load, flt;
      exp_t        e, got_e;
      @(negedge clk);
      mem_valid = v; mem_reg_write = rw; mem_rd = rd; mem_result_sel = sel;
      mem_alu_result = alu; mem_pc_plus4 = pc4; mem_read_data = rdat; mem_funct3 = f3;
      stall = st; flush = fl;
      if (fl) begin
         m_valid = 0; m_rw = 0; m_fault = 0;
      end else if (!st) begin
         model_load(rdat, f3, alu[2:0], lv, lf);
         is_load = (sel == 2'b01);
         flt     = v & is_load & lf;
         m_data  = is_load ? lv : (sel == 2'b10) ? pc4 : alu;
         m_known = !(is_load && lf);
         m_valid = v; m_rd = rd; m_fault = flt;
         m_rw    = v & rw & (rd != 5'd0) & ~flt;
         if (v) m_cnt = m_cnt + 64'd1;
      end
      e = '{m_valid, m_rd, m_data, m_known, m_rw, m_fault, m_cnt};
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      got_e = sb_q.pop_front();
      $display("txn %-10s v=%0b rd=%0d sel=%0d f3=%0d st=%0b fl=%0b -> valid=%0b rd=%0d data=%h we=%0b flt=%0b",
               name, v, rd, sel, f3, st, fl, wb_valid, wb_rd, wb_write_data, wb_reg_write, wb_load_fault);
      check_val({name, ".valid"}, {63'd0, wb_valid}, {63'd0, got_e.valid});
      check_val({name, ".rd"}, {59'd0, wb_rd}, {59'd0, got_e.rd});
      check_val({name, ".we"}, {63'd0, wb_reg_write}, {63'd0, got_e.rw});
      check_val({name, ".fault"}, {63'd0, wb_load_fault}, {63'd0, got_e.fault});
      if (got_e.data_known) check_val({name, ".data"}, wb_write_data, got_e.data);
`ifdef MEM_WB_RETIRE_CNT_EN
      check_val({name, ".cnt"}, retire_count, got_e.cnt);
`endif
   endtask

   task automatic check_zero(input string name);
      check_val({name, ".valid"}, {63'd0, wb_valid}, 64'd0);
      check_val({name, ".rd"}, {59'd0, wb_rd}, 64'd0);
      check_val({name, ".data"}, wb_write_data, 64'd0);
      check_val({name, ".we"}, {63'd0, wb_reg_write}, 64'd0);
      check_val({name, ".fault"}, {63'd0, wb_load_fault}, 64'd0);
`ifdef MEM_WB_RETIRE_CNT_EN
      check_val({name, ".cnt"}, retire_count, 64'd0);
`endif
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      reset = 1; stall = 0; flush = 0; mem_valid = 0; mem_reg_write = 0; mem_rd = 0;
      mem_result_sel = 0; mem_alu_result = 0; mem_pc_plus4 = 0; mem_read_data = 0; mem_funct3 = 0;
      model_clear();
      #22;
      $display("txn reset      outputs after reset");
      check_zero("reset");
      @(negedge clk); reset = 0;

      // Load extraction / extension
      step("lb_off7",  1, 1, 5'd2, 2'b01, 64'h1007, 64'h0, RDATA, 3'b000, 0, 0);
      step("lbu_off7", 1, 1, 5'd2, 2'b01, 64'h1007, 64'h0, RDATA, 3'b100, 0, 0);
      step("lw_off4",  1, 1, 5'd4, 2'b01, 64'h2004, 64'h0, RDATA, 3'b010, 0, 0);
      step("lwu_off4", 1, 1, 5'd4, 2'b01, 64'h2004, 64'h0, RDATA, 3'b110, 0, 0);
      step("ld_off0",  1, 1, 5'd6, 2'b01, 64'h3000, 64'h0, RDATA, 3'b011, 0, 0);
      step("lh_off2",  1, 1, 5'd7, 2'b01, 64'h3002, 64'h0, RDATA, 3'b001, 0, 0);
      step("lhu_off6", 1, 1, 5'd7, 2'b01, 64'h3006, 64'h0, RDATA, 3'b101, 0, 0);
      // Faults
      step("lh_off3",  1, 1, 5'd5, 2'b01, 64'h3003, 64'h0, RDATA, 3'b001, 0, 0);
      step("f3_111",   1, 1, 5'd5, 2'b01, 64'h3000, 64'h0, RDATA, 3'b111, 0, 0);
      step("lw_off2",  1, 1, 5'd5, 2'b01, 64'h3002, 64'h0, RDATA, 3'b010, 0, 0);
      step("ld_off4",  1, 1, 5'd5, 2'b01, 64'h3004, 64'h0, RDATA, 3'b011, 0, 0);
      step("alu_f3bad",1, 1, 5'd5, 2'b00, 64'h3003, 64'h0, RDATA, 3'b111, 0, 0);
      // Select / x0 / bubble
      step("alu_x0",   1, 1, 5'd0, 2'b00, 64'h1234, 64'h0, RDATA, 3'b000, 0, 0);
      step("pc4_rd1",  1, 1, 5'd1, 2'b10, 64'h1234, 64'h4008, RDATA, 3'b000, 0, 0);
      step("sel_rsvd", 1, 1, 5'd9, 2'b11, 64'h5555, 64'h4008, RDATA, 3'b000, 0, 0);
      step("invalid",  0, 1, 5'd9, 2'b00, 64'h7777, 64'h0, RDATA, 3'b000, 0, 0);
      // Stall hold then stall+flush
      step("cap_rd3",  1, 1, 5'd3, 2'b00, 64'hAAAA, 64'h0, RDATA, 3'b000, 0, 0);
      step("stall1",   1, 1, 5'd8, 2'b10, 64'hBBBB, 64'h11, RDATA, 3'b000, 1, 0);
      step("stall2",   1, 0, 5'd9, 2'b01, 64'hCCC1, 64'h22, RDATA, 3'b011, 1, 0);
      step("stall3",   0, 1, 5'd10,2'b00, 64'hDDDD, 64'h33, RDATA, 3'b000, 1, 0);
      step("st_fl",    1, 1, 5'd11,2'b00, 64'hEEEE, 64'h0, RDATA, 3'b000, 1, 1);
      step("recap",    1, 1, 5'd12,2'b00, 64'hF00D, 64'h0, RDATA, 3'b000, 0, 0);

      // Random mix
      for (int i = 0; i < 24; i++) begin
         step("rand", 1'($urandom), 1'($urandom), 5'($urandom), 2'($urandom),
              {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
              3'($urandom), ($urandom_range(0, 3) == 0), ($urandom_range(0, 5) == 0));
      end

      // Async reset between edges in the middle of a stall
      step("pre_rst",  1, 1, 5'd13,2'b00, 64'h9999, 64'h0, RDATA, 3'b000, 0, 0);
      @(negedge clk);
      stall = 1;
      #2 reset = 1;
      #1;
      $display("txn async_rst  outputs during mid-stall reset");
      check_zero("async_rst");
      @(negedge clk);
      reset = 0; stall = 0;
      model_clear();

      // Retire counting: 4 valid captures, 2 stalls, 1 flush
      step("rc_cap1",  1, 1, 5'd1, 2'b00, 64'h1, 64'h0, RDATA, 3'b000, 0, 0);
      step("rc_stall", 1, 1, 5'd2, 2'b00, 64'h2, 64'h0, RDATA, 3'b000, 1, 0);
      step("rc_cap2",  1, 1, 5'd3, 2'b01, 64'h3, 64'h0, RDATA, 3'b011, 0, 0);
      step("rc_flush", 1, 1, 5'd4, 2'b00, 64'h4, 64'h0, RDATA, 3'b000, 0, 1);
      step("rc_cap3",  1, 1, 5'd5, 2'b00, 64'h5, 64'h0, RDATA, 3'b000, 0, 0);
      step("rc_stall", 1, 1, 5'd6, 2'b00, 64'h6, 64'h0, RDATA, 3'b000, 1, 0);
      step("rc_cap4",  1, 0, 5'd7, 2'b10, 64'h7, 64'h70, RDATA, 3'b000, 0, 0);
`ifdef MEM_WB_RETIRE_CNT_EN
      check_val("retire4", retire_count, 64'd4);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
